// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_pipe
//  Purpose  : Registered immediate extender with a valid/ready handshake.
//             Decodes I/S/B/J/U, CSR zimm and shift-amount immediates and
//             flags the illegal select code. An optional two-entry skid buffer
//             lets the producer and consumer stall independently. A saturating
//             counter records the cycles the output spends stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
   parameter int XLEN  = 32,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      Instr,
   input  logic [2:0]       ImmSrc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ImmExt,
   output logic             ImmIllegal,
   output logic [CNT_W-1:0] StallCount
);

   // Immediate select codes
   localparam logic [2:0] c_src_i  = 3'b000;
   localparam logic [2:0] c_src_s  = 3'b001;
   localparam logic [2:0] c_src_b  = 3'b010;
   localparam logic [2:0] c_src_j  = 3'b011;
   localparam logic [2:0] c_src_u  = 3'b100;
   localparam logic [2:0] c_src_z  = 3'b101;
   localparam logic [2:0] c_src_sh = 3'b110;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   // Instr carries instruction bits [31:7], so instruction bit k sits at
   // Instr[k-7]; e.g. the sign bit (31) is Instr[24].
   logic [31:0]     w_imm32;
   logic            w_ill;
   logic            w_sh_hi;
   logic [XLEN-1:0] w_imm;
   logic [CNT_W-1:0] r_stall;

   // The 64-bit datapath takes a 6-bit shift amount (instruction bit 25)
   assign w_sh_hi = (XLEN == 64) ? Instr[18] : 1'b0;

   // Decode to a 32-bit word; bit 31 of this word is the correct fill bit for
   // every mode, since Z/SH/illegal leave it clear.
   always_comb begin
      w_imm32 = 32'd0;
      w_ill   = 1'b0;
      case (ImmSrc)
         c_src_i:  w_imm32 = {{20{Instr[24]}}, Instr[24:13]};
         c_src_s:  w_imm32 = {{20{Instr[24]}}, Instr[24:18], Instr[4:0]};
         c_src_b:  w_imm32 = {{20{Instr[24]}}, Instr[0], Instr[23:18], Instr[4:1], 1'b0};
         c_src_j:  w_imm32 = {{12{Instr[24]}}, Instr[12:5], Instr[13], Instr[23:14], 1'b0};
         c_src_u:  w_imm32 = {Instr[24:5], 12'd0};
         c_src_z:  w_imm32 = {27'd0, Instr[12:8]};
         c_src_sh: w_imm32 = {26'd0, w_sh_hi, Instr[17:13]};
         default:  w_ill   = 1'b1;
      endcase
   end

   generate
      if (XLEN == 64) begin : g_x64
         assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
      end else begin : g_x32
         assign w_imm = w_imm32;
      end

      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_extend_pipe: XLEN must be 32 or 64");
      end

      if (SKID != 0) begin : g_skid
         logic            r_out_v;
         logic            r_out_ill;
         logic [XLEN-1:0] r_out_imm;
         logic            r_skid_v;
         logic            r_skid_ill;
         logic [XLEN-1:0] r_skid_imm;
         logic            r_rdy;
         logic            w_in_xfer;
         logic            w_out_free;

         assign w_in_xfer  = in_valid && r_rdy;
         assign w_out_free = !r_out_v || out_ready;

         // Output register refills from the skid entry first, so order is kept;
         // in_ready is registered and tracks "skid entry empty".
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_out_v    <= 1'b0;
               r_out_ill  <= 1'b0;
               r_out_imm  <= '0;
               r_skid_v   <= 1'b0;
               r_skid_ill <= 1'b0;
               r_skid_imm <= '0;
               r_rdy      <= 1'b1;
            end else if (w_out_free) begin
               if (r_skid_v) begin
                  // in_ready is low while the skid is full, so no new input here
                  r_out_v   <= 1'b1;
                  r_out_imm <= r_skid_imm;
                  r_out_ill <= r_skid_ill;
                  r_skid_v  <= 1'b0;
                  r_rdy     <= 1'b1;
               end else if (w_in_xfer) begin
                  r_out_v   <= 1'b1;
                  r_out_imm <= w_imm;
                  r_out_ill <= w_ill;
               end else begin
                  r_out_v   <= 1'b0;
               end
            end else if (w_in_xfer) begin
               r_skid_v   <= 1'b1;
               r_skid_imm <= w_imm;
               r_skid_ill <= w_ill;
               r_rdy      <= 1'b0;
            end
         end

         assign in_ready   = r_rdy;
         assign out_valid  = r_out_v;
         assign ImmExt     = r_out_imm;
         assign ImmIllegal = r_out_ill;
      end else begin : g_noskid
         logic            r_out_v;
         logic            r_out_ill;
         logic [XLEN-1:0] r_out_imm;
         logic            w_rdy;

         assign w_rdy = !r_out_v || out_ready;

         // Single output stage; it can load whenever it is empty or draining
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_out_v   <= 1'b0;
               r_out_ill <= 1'b0;
               r_out_imm <= '0;
            end else if (w_rdy) begin
               r_out_v <= in_valid;
               if (in_valid) begin
                  r_out_imm <= w_imm;
                  r_out_ill <= w_ill;
               end
            end
         end

         assign in_ready   = w_rdy;
         assign out_valid  = r_out_v;
         assign ImmExt     = r_out_imm;
         assign ImmIllegal = r_out_ill;
      end
   endgenerate

   // Count stalled output cycles, sticking at the maximum instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall <= '0;
      end else if (out_valid && !out_ready && (r_stall != c_cnt_max)) begin
         r_stall <= r_stall + 1'b1;
      end
   end

   assign StallCount = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_extend_pipe
//  Purpose  : Self-checking bench for imm_extend_pipe. Instance A is XLEN=32
//             with the skid buffer, instance B is XLEN=64 without it and a
//             4-bit stall counter. A reference decoder plus an in-flight queue
//             per instance predicts every delivered word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   // Instance A: XLEN=32, SKID=1, CNT_W=16
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ill;
   logic [24:0] a_instr;
   logic [2:0]  a_src;
   logic [31:0] a_imm;
   logic [15:0] a_stall;

   // Instance B: XLEN=64, SKID=0, CNT_W=4
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ill;
   logic [24:0] b_instr;
   logic [2:0]  b_src;
   logic [63:0] b_imm;
   logic [3:0]  b_stall;

   imm_extend_pipe #(.XLEN(32), .SKID(1), .CNT_W(16)) u_a (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .Instr(a_instr), .ImmSrc(a_src),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .ImmExt(a_imm), .ImmIllegal(a_ill), .StallCount(a_stall)
   );

   imm_extend_pipe #(.XLEN(64), .SKID(0), .CNT_W(4)) u_b (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .Instr(b_instr), .ImmSrc(b_src),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .ImmExt(b_imm), .ImmIllegal(b_ill), .StallCount(b_stall)
   );

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Two's-complement value of the low 'bits' bits of val
   function automatic longint sext(input longint val, input int bits);
      longint half;
      half = longint'(1) << (bits - 1);
      return (val >= half) ? val - (half << 1) : val;
   endfunction

   // Reference decoder on the full instruction word; returns {illegal, imm64}
   function automatic logic [64:0] ref_imm(input int xlen, input logic [24:0] instr,
                                           input logic [2:0] src);
      logic [31:0] w;
      longint      v;
      logic [63:0] r;
      logic        ill;
      w   = {instr, 7'd0};
      ill = 1'b0;
      v   = 0;
      case (src)
         3'd0: v = sext(longint'(w[31:20]), 12);
         3'd1: v = sext(longint'({w[31:25], w[11:7]}), 12);
         3'd2: v = sext(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
         3'd3: v = sext(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
         3'd4: v = sext(longint'({w[31:12], 12'd0}), 32);
         3'd5: v = longint'(w[19:15]);
         3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
         default: ill = 1'b1;
      endcase
      r = v;
      if (xlen == 32) r[63:32] = 32'd0;
      return {ill, r};
   endfunction

   function automatic logic [24:0] mk(input logic [31:0] w);
      return w[31:7];
   endfunction

   // Monitor A: entries inside the DUT are exactly the queue contents
   logic [64:0] qa[$];
   int          a_stall_m = 0;
   int          a_nout = 0;
   logic        a_hold = 1'b0;
   logic [32:0] a_last;
   always @(negedge clk) begin
      if (reset) begin
         qa.delete();
         a_stall_m = 0;
         a_hold    = 1'b0;
      end else begin
         chk("a_out_valid", 65'(a_out_valid), 65'(qa.size() != 0));
         chk("a_in_ready", 65'(a_in_ready), 65'(qa.size() < 2));
         chk("a_stall_count", 65'(a_stall), 65'(a_stall_m));
         if (a_hold) chk("a_hold_stable", 65'({a_ill, a_imm}), 65'(a_last));
         if (a_out_valid && a_out_ready && qa.size() != 0) begin
            chk("a_out_data", {a_ill, 32'd0, a_imm}, qa.pop_front());
            a_nout++;
         end
         if (a_in_valid && a_in_ready) qa.push_back(ref_imm(32, a_instr, a_src));
         if (a_out_valid && !a_out_ready && a_stall_m < 65535) a_stall_m++;
         a_hold = a_out_valid && !a_out_ready;
         a_last = {a_ill, a_imm};
      end
   end

   // Monitor B
   logic [64:0] qb[$];
   int          b_stall_m = 0;
   int          b_nout = 0;
   logic        b_hold = 1'b0;
   logic [64:0] b_last;
   always @(negedge clk) begin
      if (reset) begin
         qb.delete();
         b_stall_m = 0;
         b_hold    = 1'b0;
      end else begin
         chk("b_out_valid", 65'(b_out_valid), 65'(qb.size() != 0));
         chk("b_in_ready", 65'(b_in_ready), 65'(qb.size() == 0 || b_out_ready));
         chk("b_stall_count", 65'(b_stall), 65'(b_stall_m));
         if (b_hold) chk("b_hold_stable", {b_ill, b_imm}, b_last);
         if (b_out_valid && b_out_ready && qb.size() != 0) begin
            chk("b_out_data", {b_ill, b_imm}, qb.pop_front());
            b_nout++;
         end
         if (b_in_valid && b_in_ready) qb.push_back(ref_imm(64, b_instr, b_src));
         if (b_out_valid && !b_out_ready && b_stall_m < 15) b_stall_m++;
         b_hold = b_out_valid && !b_out_ready;
         b_last = {b_ill, b_imm};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word and hold it until accepted (bounded)
   task automatic send(input bit to_b, input logic [24:0] ins, input logic [2:0] src,
                       input bit rnd_bp);
      bit took;
      took = 1'b0;
      if (to_b) begin b_in_valid = 1'b1; b_instr = ins; b_src = src; end
      else      begin a_in_valid = 1'b1; a_instr = ins; a_src = src; end
      for (int i = 0; i < 64 && !took; i++) begin
         @(negedge clk);
         took = to_b ? b_in_ready : a_in_ready;
         @(posedge clk);
         #1;
         if (rnd_bp) begin
            if (to_b) b_out_ready = 1'($urandom_range(0, 1));
            else      a_out_ready = 1'($urandom_range(0, 1));
         end
      end
      if (to_b) b_in_valid = 1'b0;
      else      a_in_valid = 1'b0;
      chk(to_b ? "b_accept" : "a_accept", 65'(took), 65'd1);
   endtask

   task automatic sendchk_a(input string tag, input logic [31:0] w, input logic [2:0] src,
                            input logic [32:0] exp);
      send(1'b0, mk(w), src, 1'b0);
      @(negedge clk);
      chk(tag, 65'({a_ill, a_imm}), 65'(exp));
      tick();
   endtask

   task automatic sendchk_b(input string tag, input logic [31:0] w, input logic [2:0] src,
                            input logic [64:0] exp);
      send(1'b1, mk(w), src, 1'b0);
      @(negedge clk);
      chk(tag, {b_ill, b_imm}, exp);
      tick();
   endtask

   initial begin
      int c0;
      int n0;
      reset = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_instr = '0; a_src = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_instr = '0; b_src = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_valid", 65'(a_out_valid), 65'd0);
      chk("rst_a_imm", 65'({a_ill, a_imm}), 65'd0);
      chk("rst_a_stall", 65'(a_stall), 65'd0);
      chk("rst_b_valid", 65'(b_out_valid), 65'd0);
      chk("rst_b_imm", {b_ill, b_imm}, 65'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_a_in_ready", 65'(a_in_ready), 65'd1);
      chk("rst_b_in_ready", 65'(b_in_ready), 65'd1);
      tick();

      // Decode sweep, XLEN=32
      sendchk_a("dec_I",  32'hFFF00000, 3'd0, {1'b0, 32'hFFFFFFFF});
      sendchk_a("dec_S",  32'hFE000F80, 3'd1, {1'b0, 32'hFFFFFFFF});
      sendchk_a("dec_B",  32'h00000080, 3'd2, {1'b0, 32'h00000800});
      sendchk_a("dec_J",  32'h00100000, 3'd3, {1'b0, 32'h00000800});
      sendchk_a("dec_U",  32'h12345000, 3'd4, {1'b0, 32'h12345000});
      sendchk_a("dec_SH32", 32'h03F00000, 3'd6, {1'b0, 32'h0000001F});
      sendchk_a("dec_ill", 32'hFFFFFFFF, 3'd7, {1'b1, 32'h00000000});
      sendchk_a("dec_after_ill", 32'h00100000, 3'd0, {1'b0, 32'h00000001});

      // Decode checks, XLEN=64
      sendchk_b("dec64_U",  32'h80000000, 3'd4, {1'b0, 64'hFFFFFFFF_80000000});
      sendchk_b("dec64_SH", 32'h03F00000, 3'd6, {1'b0, 64'h3F});
      sendchk_b("dec64_Z",  32'h000F8000, 3'd5, {1'b0, 64'h1F});
      sendchk_b("dec64_I",  32'h80000000, 3'd0, {1'b0, 64'hFFFFFFFF_FFFFF800});

      // Backpressure with skid on A: A, B, C back to back, 3 stalled cycles
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_src = 3'd4;
      a_instr = mk(32'h11111000); tick();
      a_instr = mk(32'h22222000); tick();
      a_instr = mk(32'h33333000);
      @(negedge clk);
      chk("bp_in_ready_low", 65'(a_in_ready), 65'd0);
      tick(); tick();
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("bp_stall3", 65'(a_stall), 65'd3);
      chk("bp_first", 65'({a_ill, a_imm}), 65'(33'h011111000));
      tick();
      @(negedge clk);
      chk("bp_second", 65'({a_ill, a_imm}), 65'(33'h022222000));
      tick();
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("bp_third", 65'({a_ill, a_imm}), 65'(33'h033333000));
      tick();

      // Reset mid-stream with the output held and the skid full
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_instr = mk(32'h00500000); a_src = 3'd0;
      tick(); tick();
      a_in_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 65'(a_out_valid), 65'd0);
      chk("mid_rst_imm", 65'({a_ill, a_imm}), 65'd0);
      chk("mid_rst_stall", 65'(a_stall), 65'd0);
      a_out_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", 65'(a_in_ready), 65'd1);
      tick();

      // Stall counter saturation on B (4-bit)
      b_out_ready = 1'b0;
      send(1'b1, mk(32'h00100000), 3'd0, 1'b0);
      repeat (20) tick();
      @(negedge clk);
      chk("sat_15", 65'(b_stall), 65'd15);
      tick();
      @(negedge clk);
      chk("sat_hold", 65'(b_stall), 65'd15);
      tick();
      b_out_ready = 1'b1;
      tick(); tick();

      // Full-rate throughput, both configurations
      c0 = cyc; n0 = a_nout;
      for (int i = 0; i < 100; i++) send(1'b0, 25'($urandom), 3'($urandom_range(0, 7)), 1'b0);
      chk("a_tput_cycles", 65'(cyc - c0), 65'd100);
      tick(); tick();
      chk("a_tput_outputs", 65'(a_nout - n0), 65'd100);

      c0 = cyc; n0 = b_nout;
      for (int i = 0; i < 100; i++) send(1'b1, 25'($urandom), 3'($urandom_range(0, 7)), 1'b0);
      chk("b_tput_cycles", 65'(cyc - c0), 65'd100);
      tick(); tick();
      chk("b_tput_outputs", 65'(b_nout - n0), 65'd100);

      // Random backpressure
      for (int i = 0; i < 60; i++) send(1'b0, 25'($urandom), 3'($urandom_range(0, 7)), 1'b1);
      for (int i = 0; i < 60; i++) send(1'b1, 25'($urandom), 3'($urandom_range(0, 7)), 1'b1);
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      repeat (4) tick();
      chk("a_drained", 65'(qa.size()), 65'd0);
      chk("b_drained", 65'(qb.size()), 65'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
